// File: rtl/sticker_issue_queue.sv
// sticker_issue_queue
//   Buffers (height, width) sticker requests from a valid/ready producer and
//   replays them to the placer at a fixed cadence: each slot is PERIOD cycles
//   long, and one pair is held on height_o/width_o for the whole slot. A slot
//   with nothing queued carries a 0/0 bubble.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active high
//   in_valid_i   producer has a request
//   in_ready_o   queue can accept a request this cycle (combinational)
//   in_height_i  request height
//   in_width_i   request width
//   height_o     registered height to the placer
//   width_o      registered width to the placer
//   issue_o      pulse on the first cycle of a slot carrying a real pair
//   phase_o      cadence phase, 0 on the first cycle of a slot
//   count_o      FIFO occupancy
//   issued_o     pairs issued since reset, saturating
module sticker_issue_queue #(
   parameter int DEPTH  = 8,
   parameter int PERIOD = 4,
   parameter int DIM_W  = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [DIM_W-1:0]         in_height_i,
   input  logic [DIM_W-1:0]         in_width_i,
   output logic [DIM_W-1:0]         height_o,
   output logic [DIM_W-1:0]         width_o,
   output logic                     issue_o,
   output logic [1:0]               phase_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [15:0]              issued_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = ($clog2(PERIOD) < 2) ? 2 : $clog2(PERIOD);

   logic [DIM_W-1:0] r_mem_h [DEPTH];
   logic [DIM_W-1:0] r_mem_w [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    r_phase;
   logic [DIM_W-1:0] r_height;
   logic [DIM_W-1:0] r_width;
   logic             r_issue;
   logic [15:0]      r_issued;

   logic w_ready;
   logic w_accept;
   logic w_push;
   logic w_boundary;
   logic w_pop;

   assign w_ready    = (r_count < CW'(DEPTH)) && !rst_i;
   // Null requests complete the handshake but are never stored.
   assign w_accept   = in_valid_i && w_ready;
   assign w_push     = w_accept && (in_height_i != '0) && (in_width_i != '0);
   assign w_boundary = (r_phase == PW'(PERIOD - 1));
   // Pop only uses pre-edge occupancy, so a same-edge push is never bypassed.
   assign w_pop      = w_boundary && (r_count != '0);

   // Storage array carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem_h[r_wr_ptr] <= in_height_i;
         r_mem_w[r_wr_ptr] <= in_width_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_phase  <= PW'(PERIOD - 1);
         r_height <= '0;
         r_width  <= '0;
         r_issue  <= 1'b0;
         r_issued <= '0;
      end else begin
         r_phase <= w_boundary ? '0 : r_phase + 1'b1;

         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         end

         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end

         if (w_boundary) begin
            if (w_pop) begin
               r_height <= r_mem_h[r_rd_ptr];
               r_width  <= r_mem_w[r_rd_ptr];
               r_issue  <= 1'b1;
               r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
               if (r_issued != '1) begin
                  r_issued <= r_issued + 1'b1;
               end
            end else begin
               r_height <= '0;
               r_width  <= '0;
               r_issue  <= 1'b0;
            end
         end else begin
            r_issue <= 1'b0;
         end
      end
   end

   assign in_ready_o = w_ready;
   assign height_o   = r_height;
   assign width_o    = r_width;
   assign issue_o    = r_issue;
   assign phase_o    = r_phase[1:0];
   assign count_o    = r_count;
   assign issued_o   = r_issued;

endmodule

// File: tb/tb_sticker_issue_queue.sv
// Bench for sticker_issue_queue: directed steps plus random traffic, checked
// every cycle against a queue-based model of the issue cadence.
module tb_sticker_issue_queue;

   localparam int DEPTH  = 8;
   localparam int PERIOD = 4;
   localparam int DIM_W  = 5;

   logic                   clk = 1'b0;
   logic                   rst_i;
   logic                   in_valid_i;
   logic                   in_ready_o;
   logic [DIM_W-1:0]       in_height_i;
   logic [DIM_W-1:0]       in_width_i;
   logic [DIM_W-1:0]       height_o;
   logic [DIM_W-1:0]       width_o;
   logic                   issue_o;
   logic [1:0]             phase_o;
   logic [$clog2(DEPTH):0] count_o;
   logic [15:0]            issued_o;

   sticker_issue_queue #(.DEPTH(DEPTH), .PERIOD(PERIOD), .DIM_W(DIM_W)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_height_i(in_height_i),
      .in_width_i (in_width_i),
      .height_o   (height_o),
      .width_o    (width_o),
      .issue_o    (issue_o),
      .phase_o    (phase_o),
      .count_o    (count_o),
      .issued_o   (issued_o)
   );

   always #5 clk = ~clk;

   typedef struct { int h; int w; } pair_t;
   pair_t q[$];
   int    k;        // edges since reset release
   int    eh, ew, eiss, eissued;
   int    n_assert = 0;
   int    n_fail   = 0;
   int    n_issue_pulses;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_phase();
      if (rst_i || k == 0) return PERIOD - 1;
      return (k - 1) % PERIOD;
   endfunction

   task automatic model_reset();
      q.delete();
      k = 0; eh = 0; ew = 0; eiss = 0; eissued = 0;
   endtask

   task automatic check_all();
      chk("phase",  int'(phase_o),  exp_phase());
      chk("height", int'(height_o), eh);
      chk("width",  int'(width_o),  ew);
      chk("issue",  int'(issue_o),  eiss);
      chk("count",  int'(count_o),  q.size());
      chk("issued", int'(issued_o), eissued);
      chk("ready",  int'(in_ready_o), (q.size() < DEPTH && !rst_i) ? 1 : 0);
   endtask

   // One clock edge: model the edge from the pre-edge inputs, then compare.
   task automatic step();
      bit    acc;
      int    h, w;
      pair_t p;
      acc = in_valid_i && (q.size() < DEPTH) && !rst_i;
      h = int'(in_height_i);
      w = int'(in_width_i);
      @(posedge clk);
      if (!rst_i) begin
         k++;
         if ((k - 1) % PERIOD == 0) begin
            if (q.size() > 0) begin
               p = q.pop_front();
               eh = p.h; ew = p.w; eiss = 1;
               if (eissued < 65535) eissued++;
            end else begin
               eh = 0; ew = 0; eiss = 0;
            end
         end else begin
            eiss = 0;
         end
         if (acc && h != 0 && w != 0) q.push_back('{h, w});
      end
      #1;
      if (issue_o) n_issue_pulses++;
      check_all();
   endtask

   task automatic drive(input bit v, input int h, input int w);
      in_valid_i  = v;
      in_height_i = DIM_W'(h);
      in_width_i  = DIM_W'(w);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      #1;
      model_reset();
      check_all();
      step();
      rst_i = 1'b0;
      n_issue_pulses = 0;
   endtask

   initial begin
      int guard;
      rst_i = 1'b1;
      drive(0, 0, 0);
      model_reset();
      n_issue_pulses = 0;
      #2;
      do_reset();

      // Idle after reset: bubbles only, phase 0,1,2,3,...
      for (int i = 0; i < 12; i++) step();
      chk("idle_no_issue", n_issue_pulses, 0);

      // Three pushes immediately after release.
      do_reset();
      drive(1, 3, 5);   step();
      drive(1, 16, 16); step();
      drive(1, 1, 31);  step();
      drive(0, 0, 0);
      for (int i = 0; i < 14; i++) step();
      chk("three_pulses", n_issue_pulses, 3);
      chk("three_issued", int'(issued_o), 3);

      // Null request is dropped.
      do_reset();
      drive(1, 0, 7); step();
      drive(1, 4, 4); step();
      chk("null_count_peak", int'(count_o), 1);
      drive(0, 0, 0);
      for (int i = 0; i < 8; i++) step();
      chk("null_issued", int'(issued_o), 1);

      // Back-pressure: hold valid 12 cycles with distinct pairs.
      do_reset();
      for (int i = 0; i < 12; i++) begin
         drive(1, i + 1, 30 - i);
         step();
      end
      drive(0, 0, 0);
      for (int i = 0; i < 40; i++) step();
      chk("fill_drained", int'(count_o), 0);

      // Push on the boundary edge into an empty FIFO: no bypass.
      guard = 0;
      while (!(phase_o == 2'(PERIOD - 1) && q.size() == 0) && guard < 50) begin
         step(); guard++;
      end
      chk("align_bound", (guard < 50) ? 1 : 0, 1);
      drive(1, 9, 10); step();
      drive(0, 0, 0);
      chk("nobypass_h", int'(height_o), 0);
      chk("nobypass_issue", int'(issue_o), 0);
      for (int i = 0; i < PERIOD; i++) step();
      chk("late_h", int'(height_o), 9);
      chk("late_w", int'(width_o), 10);

      // Random traffic, nulls included.
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31));
         step();
      end
      drive(0, 0, 0);

      // Mid-operation asynchronous reset with 5 entries queued.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1, i + 2, i + 3);
         step();
      end
      drive(0, 0, 0);
      guard = 0;
      while (!(q.size() == 5 && eh != 0) && guard < 50) begin
         step(); guard++;
      end
      chk("fill5_bound", (guard < 50) ? 1 : 0, 1);
      rst_i = 1'b1;
      #2;
      chk("async_h", int'(height_o), 0);
      chk("async_w", int'(width_o), 0);
      chk("async_count", int'(count_o), 0);
      chk("async_phase", int'(phase_o), PERIOD - 1);
      model_reset();
      step();
      rst_i = 1'b0;
      step();
      chk("restart_phase", int'(phase_o), 0);
      for (int i = 0; i < 6; i++) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
